// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver and the reaction-game controller.
package led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 3'd2;
    localparam logic [MODE_W-1:0] MODE_BAR   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_CHASE = 3'd4;

    // Direction of the chase FSM.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } chase_dir_e;

    // Thermometer mask: bit i set for every i < fill.
    function automatic logic [31:0] fill_mask(input logic [31:0] fill);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            m[i] = (32'(i) < fill);
        end
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-tick prescaler: counts 0..TICK_DIV-1 and flags the last count
// combinationally. clr restarts the count from zero on the next edge.
module led_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over the natural wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_pattern_driver.sv
// N-wide LED bank driver: off / on / blink / bar-graph / chase patterns,
// advanced by an internal prescaled tick, with active-high blanking.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int N_LEDS   = 10,
    parameter int TICK_DIV = 12_500_000,
    parameter int BOUNCE   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MODE_W-1:0]             mode,
    input  logic [$clog2(N_LEDS+1)-1:0]   level,
    input  logic                          disp,
    output logic [N_LEDS-1:0]             ledr,
    output logic                          tick
);

    localparam int LVL_W = $clog2(N_LEDS + 1);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_LEDS - 2);

    logic [MODE_W-1:0] mode_q,      mode_d;
    logic              tick_q,      tick_d;
    logic [N_LEDS-1:0] ledr_q,      ledr_d;
    logic              blink_ph_q,  blink_ph_d;
    logic [POS_W-1:0]  chase_pos_q, chase_pos_d;
    chase_dir_e        chase_dir_q, chase_dir_d;

    logic              tick_i;
    logic              restart_s;
    logic [31:0]       bar_s;
    logic [N_LEDS-1:0] chase_s;
    logic [N_LEDS-1:0] pattern_s;

    // A mode change restarts the prescaler and every phase.
    assign restart_s = (mode != mode_q);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart_s),
        .tick  (tick_i)
    );

    // Phase update: restart beats a coincident tick; phases run in every mode.
    always_comb begin
        mode_d      = mode;
        tick_d      = tick_i;
        blink_ph_d  = blink_ph_q;
        chase_pos_d = chase_pos_q;
        chase_dir_d = chase_dir_q;
        if (restart_s) begin
            blink_ph_d  = 1'b0;
            chase_pos_d = {POS_W{1'b0}};
            chase_dir_d = DIR_UP;
        end else if (tick_i) begin
            blink_ph_d = ~blink_ph_q;
            if (N_LEDS == 1) begin
                chase_pos_d = {POS_W{1'b0}};
                chase_dir_d = DIR_UP;
            end else if (BOUNCE != 0) begin
                case (chase_dir_q)
                    DIR_UP: begin
                        if (chase_pos_q == POS_LAST) begin
                            chase_dir_d = DIR_DOWN;
                            chase_pos_d = POS_PREV;
                        end else begin
                            chase_pos_d = chase_pos_q + POS_W'(1);
                        end
                    end
                    DIR_DOWN: begin
                        if (chase_pos_q == {POS_W{1'b0}}) begin
                            chase_dir_d = DIR_UP;
                            chase_pos_d = POS_W'(1);
                        end else begin
                            chase_pos_d = chase_pos_q - POS_W'(1);
                        end
                    end
                    default: begin
                        chase_dir_d = DIR_UP;
                        chase_pos_d = {POS_W{1'b0}};
                    end
                endcase
            end else begin
                chase_dir_d = DIR_UP;
                if (chase_pos_q == POS_LAST) begin
                    chase_pos_d = {POS_W{1'b0}};
                end else begin
                    chase_pos_d = chase_pos_q + POS_W'(1);
                end
            end
        end else begin
            blink_ph_d = blink_ph_q;
        end
    end

    // Pattern from the live mode input, then blanking.
    always_comb begin
        bar_s   = fill_mask(32'(level));
        chase_s = {N_LEDS{1'b0}};
        for (int i = 0; i < N_LEDS; i++) begin
            chase_s[i] = (32'(chase_pos_q) == 32'(i));
        end
        case (mode)
            MODE_OFF:   pattern_s = {N_LEDS{1'b0}};
            MODE_ON:    pattern_s = {N_LEDS{1'b1}};
            MODE_BLINK: pattern_s = {N_LEDS{blink_ph_q}};
            MODE_BAR:   pattern_s = bar_s[N_LEDS-1:0];
            MODE_CHASE: pattern_s = chase_s;
            default:    pattern_s = {N_LEDS{1'b0}};
        endcase
        if (disp) begin
            ledr_d = {N_LEDS{1'b0}};
        end else begin
            ledr_d = pattern_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            tick_q      <= 1'b0;
            ledr_q      <= {N_LEDS{1'b0}};
            blink_ph_q  <= 1'b0;
            chase_pos_q <= {POS_W{1'b0}};
            chase_dir_q <= DIR_UP;
        end else begin
            mode_q      <= mode_d;
            tick_q      <= tick_d;
            ledr_q      <= ledr_d;
            blink_ph_q  <= blink_ph_d;
            chase_pos_q <= chase_pos_d;
            chase_dir_q <= chase_dir_d;
        end
    end

    assign ledr = ledr_q;
    assign tick = tick_q;

    logic unused_s;
    assign unused_s = ^{bar_s[31:N_LEDS], LVL_W[0]};

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver (N_LEDS=10, TICK_DIV=4); a second
// instance with BOUNCE=0 shares all inputs for the wrap-around chase case.
module tb_led_pattern_driver;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic [3:0] level;
    logic       disp;
    logic [9:0] ledr_a;
    logic       tick_a;
    logic [9:0] ledr_b;
    logic       tick_b;

    int n_checks;
    int n_fail;

    int seq_a [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int seq_b [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    led_pattern_driver #(.N_LEDS(10), .TICK_DIV(4), .BOUNCE(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .level (level),
        .disp  (disp),
        .ledr  (ledr_a),
        .tick  (tick_a)
    );

    led_pattern_driver #(.N_LEDS(10), .TICK_DIV(4), .BOUNCE(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .level (level),
        .disp  (disp),
        .ledr  (ledr_b),
        .tick  (tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [9:0] one;
        n_checks = 0;
        n_fail   = 0;
        one      = 10'h001;
        rst_n    = 1'b0;
        mode     = 3'd0;
        level    = 4'd0;
        disp     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ledr", 32'(ledr_a), 32'h000);
        chk("rst_tick", 32'(tick_a), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("off_ledr", 32'(ledr_a), 32'h000);

        // Blanking in ON mode
        mode = 3'd1;
        @(negedge clk);
        chk("on_ledr", 32'(ledr_a), 32'h3FF);
        disp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("disp_blank", 32'(ledr_a), 32'h000);
        end
        disp = 1'b0;
        @(negedge clk);
        chk("disp_release", 32'(ledr_a), 32'h3FF);

        // Bar graph
        mode  = 3'd3;
        level = 4'd0;
        @(negedge clk);
        chk("bar_0", 32'(ledr_a), 32'h000);
        level = 4'd3;
        @(negedge clk);
        chk("bar_3", 32'(ledr_a), 32'h007);
        level = 4'd10;
        @(negedge clk);
        chk("bar_10", 32'(ledr_a), 32'h3FF);
        level = 4'd15;
        @(negedge clk);
        chk("bar_15", 32'(ledr_a), 32'h3FF);

        // Blink: restart on entry, toggle every 4 cycles
        mode = 3'd2;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk("blink_ledr", 32'(ledr_a), (((k - 2) / 4) % 2 == 1) ? 32'h3FF : 32'h000);
                chk("blink_tick", 32'(tick_a), (k >= 5 && (k - 1) % 4 == 0) ? 32'h1 : 32'h0);
            end
        end

        // Chase: bounce (A) and wrap (B)
        mode = 3'd4;
        for (int k = 1; k <= 78; k++) begin
            @(negedge clk);
            if (k >= 2 && (k - 2) % 4 == 0) begin
                chk("chase_bounce", 32'(ledr_a), 32'(one << seq_a[(k - 2) / 4]));
                chk("chase_wrap",   32'(ledr_b), 32'(one << seq_b[(k - 2) / 4]));
            end
        end

        // Mode change coincident with a tick: restart wins
        repeat (2) @(negedge clk);
        chk("pre_restart_pos", 32'(ledr_a), 32'h002);
        mode  = 3'd3;
        level = 4'd0;
        @(negedge clk);
        chk("restart_bar", 32'(ledr_a), 32'h000);
        chk("restart_tick", 32'(tick_a), 32'h1);
        mode = 3'd4;
        @(negedge clk);
        chk("restart_pos0", 32'(ledr_a), 32'h001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("restart_hold", 32'(ledr_a), 32'h001);
            chk("restart_notick", 32'(tick_a), 32'h0);
        end
        @(negedge clk);
        chk("restart_next_tick", 32'(tick_a), 32'h1);
        chk("restart_still0", 32'(ledr_a), 32'h001);
        @(negedge clk);
        chk("restart_step1", 32'(ledr_a), 32'h002);

        // Asynchronous reset mid-run in ON mode
        mode = 3'd1;
        repeat (2) @(negedge clk);
        chk("on_before_rst", 32'(ledr_a), 32'h3FF);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ledr", 32'(ledr_a), 32'h000);
        chk("async_rst_tick", 32'(tick_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("post_rst_tick", 32'(tick_a), (k == 5) ? 32'h1 : 32'h0);
            if (k == 1) begin
                chk("post_rst_ledr", 32'(ledr_a), 32'h3FF);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
- Parametrised successor to the board's fixed all-on/all-off LEDR driver.
- Drives an N-wide red LED bank in one of five patterns: off, on, blink, bar-graph, chase.
- Has an internal tick prescaler.
- Keeps the existing active-high `disp` blanking input, so game FSMs can blank the bank without changing mode.
- Sits between the reaction-game controller and the LEDR pins.

Parameters:
- N_LEDS, 10, number of LEDs driven (1..32).
- TICK_DIV, 12_500_000, clk cycles per pattern tick (>=2); 4 Hz at 50 MHz.
- BOUNCE, 1, chase mode: 1 = bounce at the ends, 0 = wrap from N_LEDS-1 to 0.

Ports:
- clk, input, 1, system clock, rising-edge active.
- rst_n, input, 1, asynchronous active-low reset.
- mode, input, 3, pattern select: 0 OFF, 1 ON, 2 BLINK, 3 BAR, 4 CHASE, 5-7 reserved.
- level, input, $clog2(N_LEDS+1), bar-graph fill count.
- disp, input, 1, blanking; 1 forces all LEDs off.
- ledr, output, N_LEDS, LED drive; ledr[0] = LEDR0; 1 = lit.
- tick, output, 1, one-cycle pulse on each pattern tick, for external sync.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: ledr=0, tick=0, prescaler cnt=0, blink_ph=0, chase_pos=0, chase_dir=up, mode_q=OFF.
- Reset release mid-pattern restarts every phase from these values.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - The internal tick_i is asserted combinationally while cnt==TICK_DIV-1.
  - The tick output is tick_i registered, so it lags tick_i by one cycle. Period is exactly TICK_DIV cycles.
- Mode-change restart:
  - mode_q registers mode every cycle.
  - When mode != mode_q, the next edge clears cnt, blink_ph and chase_pos, and sets chase_dir=up.
  - This restart has priority over a coincident tick_i.
- Phase update on tick_i (no mode change that cycle):
  - blink_ph toggles.
  - chase_pos advances by one in chase_dir.
  - BOUNCE=1: at pos N_LEDS-1 going up, dir flips to down and the next pos is N_LEDS-2. At pos 0 going down, dir flips to up and the next pos is 1.
  - BOUNCE=0: N_LEDS-1 -> 0, always up.
  - N_LEDS=1: pos stays 0.
  - Phases advance in every mode, so blink and chase run consistently.
- Pattern, computed from the current mode (not mode_q):
  - OFF: all 0.
  - ON: all 1.
  - BLINK: all bits = blink_ph.
  - BAR: ledr[i]=1 for i<level. level>=N_LEDS gives all 1; level=0 gives all 0.
  - CHASE: one-hot at chase_pos.
  - 5-7: all 0.
- Output:
  - ledr <= disp ? 0 : pattern, registered every cycle.
  - Latency is 1 cycle from mode, level or disp to ledr.
  - disp has priority over every mode. It does not stop the prescaler or the phases.
- Simultaneous events:
  - Mode change and disp together: ledr=0, and phases still restart.
  - level change: takes effect with 1-cycle latency, with no restart.
- No glitches: ledr comes straight from flops.

Decomposition:
- Shared package led_pkg holds:
  - localparams MODE_OFF=3'd0, MODE_ON=3'd1, MODE_BLINK=3'd2, MODE_BAR=3'd3, MODE_CHASE=3'd4;
  - the mode width constant MODE_W=3.
  - The game controller imports the same package.
- One sub-module, led_tick_gen (params TICK_DIV; ports clk, rst_n, clr, tick). It holds the prescaler and the combinational tick pulse. The top level registers the pulse for its tick output.
- Pattern generation and the chase FSM (dir up/down) stay in the top level.

Test Plan:
All scenarios use N_LEDS=10, TICK_DIV=4, BOUNCE=1 unless stated.
1. Assert rst_n=0 mid-run with mode=ON, then release -> ledr=10'h000 immediately (async), tick=0, and the first tick pulse comes 5 cycles after release (4 to tick_i, +1 register).
2. mode=ON, then disp=1 for 3 cycles, then 0 -> ledr=10'h3FF, then 10'h000 one cycle after disp rises, then 10'h3FF one cycle after it falls.
3. mode=BAR, level = 0, 3, 10, 15 -> ledr = 10'h000, 10'h007, 10'h3FF, 10'h3FF, each 1 cycle after level changes.
4. mode=BLINK held 20 cycles -> ledr toggles between 10'h000 and 10'h3FF every 4 cycles, starting at 10'h000; tick pulses align with each toggle edge.
5. mode=CHASE for 20 ticks -> lit index sequence 0,1,...,9,8,...,0,1. Rerun with BOUNCE=0 -> sequence 9,0,1.
6. Switch CHASE->BAR->CHASE with a mode change on the same cycle as a tick -> chase restarts at index 0, direction up, with no skipped step; the next tick arrives 4 cycles after the restart.
